// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit: RV32I access-size codes and FSM state encodings.
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StReq  = 2'b01,
      StDone = 2'b10
   } lsuState_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the load/store unit (master) and data memory (slave).
interface load_store_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [3:0]      dmem_be;
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: legality check, byte enables, store replication, load extension.
module load_store_unit_align
   import load_store_unit_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            memRead_i,
   input  logic            memWrite_i,
   input  logic [2:0]      reqFunct3_i,
   input  logic [1:0]      reqOff_i,
   input  logic [XLEN-1:0] storeIn_i,
   input  logic [2:0]      rspFunct3_i,
   input  logic [1:0]      rspOff_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic            legal_o,
   output logic [3:0]      be_o,
   output logic [XLEN-1:0] storeOut_o,
   output logic [XLEN-1:0] loadOut_o
);

   logic       rdOk, wrOk, misaligned;
   logic [7:0] byteVal;
   logic [15:0] halfVal;

   always_comb begin
      rdOk       = reqFunct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      wrOk       = reqFunct3_i inside {F3_B, F3_H, F3_W};
      misaligned = ((reqFunct3_i[1:0] == 2'b01) && reqOff_i[0]) ||
                   ((reqFunct3_i[1:0] == 2'b10) && (reqOff_i != 2'b00));
      legal_o    = (memRead_i ^ memWrite_i) && (memRead_i ? rdOk : wrOk) && !misaligned;

      be_o       = 4'b1111;
      storeOut_o = storeIn_i;
      case (reqFunct3_i[1:0])
         2'b00: begin
            be_o       = 4'b0001 << reqOff_i;
            storeOut_o = {(XLEN/8){storeIn_i[7:0]}};
         end
         2'b01: begin
            be_o       = reqOff_i[1] ? 4'b1100 : 4'b0011;
            storeOut_o = {(XLEN/16){storeIn_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Load lane selection uses the offset/size captured at issue, not the live pipeline inputs.
   always_comb begin
      byteVal = rdata_i[{rspOff_i, 3'b000} +: 8];
      halfVal = rspOff_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (rspFunct3_i)
         F3_B:    loadOut_o = {{(XLEN-8){byteVal[7]}}, byteVal};
         F3_BU:   loadOut_o = {{(XLEN-8){1'b0}}, byteVal};
         F3_H:    loadOut_o = {{(XLEN-16){halfVal[15]}}, halfVal};
         F3_HU:   loadOut_o = {{(XLEN-16){1'b0}}, halfVal};
         default: loadOut_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one access at a time over a req/ack bus, with stall, timeout
// and access-error reporting.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [2:0]         funct3,
   input  logic [XLEN-1:0]    addr,
   input  logic [XLEN-1:0]    wdata,
   input  logic               flush,
   output logic               stall,
   output logic               load_valid,
   output logic [XLEN-1:0]    load_data,
   output logic               access_err,
   output logic               bus_err,
   load_store_unit_if.master  dmem
);

   localparam int unsigned    CntW       = $clog2(TIMEOUT_CYC + 2);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYC);

   lsuState_e       stateQ, stateD;
   logic [CntW-1:0] cntQ, cntD;
   logic            killQ, killD;
   logic            accessErrQ, accessErrD;
   logic            busErrQ, busErrD;
   logic            issue;
   logic            weQ;
   logic [2:0]      funct3Q;
   logic [1:0]      offQ;
   logic [XLEN-1:0] dmemAddrQ, dmemWdataQ, loadDataQ;
   logic [3:0]      dmemBeQ;

   logic            legal;
   logic [3:0]      beNext;
   logic [XLEN-1:0] storeData, loadExt;

   load_store_unit_align #(
      .XLEN (XLEN)
   ) uAlign (
      .memRead_i   (mem_read),
      .memWrite_i  (mem_write),
      .reqFunct3_i (funct3),
      .reqOff_i    (addr[1:0]),
      .storeIn_i   (wdata),
      .rspFunct3_i (funct3Q),
      .rspOff_i    (offQ),
      .rdata_i     (dmem.dmem_rdata),
      .legal_o     (legal),
      .be_o        (beNext),
      .storeOut_o  (storeData),
      .loadOut_o   (loadExt)
   );

   always_comb begin
      stateD     = stateQ;
      cntD       = cntQ;
      killD      = killQ;
      accessErrD = 1'b0;
      busErrD    = 1'b0;
      issue      = 1'b0;
      stall      = 1'b0;
      case (stateQ)
         StIdle: begin
            if (mem_read || mem_write) begin
               if (legal) begin
                  issue  = 1'b1;
                  stall  = 1'b1;
                  stateD = StReq;
                  cntD   = '0;
                  killD  = 1'b0;
               end else begin
                  accessErrD = 1'b1;
               end
            end
         end
         StReq: begin
            stall = 1'b1;
            cntD  = cntQ + CntW'(1);
            if (flush) killD = 1'b1;
            // An ack in the final allowed cycle still wins over the timeout.
            if (dmem.dmem_ack) begin
               stateD = StDone;
            end else if ((TIMEOUT_CYC != 0) && (cntQ + CntW'(1) == TimeoutVal)) begin
               stateD  = StIdle;
               busErrD = 1'b1;
            end
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ     <= StIdle;
         cntQ       <= '0;
         killQ      <= 1'b0;
         accessErrQ <= 1'b0;
         busErrQ    <= 1'b0;
         weQ        <= 1'b0;
         funct3Q    <= F3_B;
         offQ       <= 2'b00;
         dmemAddrQ  <= '0;
         dmemWdataQ <= '0;
         dmemBeQ    <= 4'b0000;
         loadDataQ  <= '0;
      end else begin
         stateQ     <= stateD;
         cntQ       <= cntD;
         killQ      <= killD;
         accessErrQ <= accessErrD;
         busErrQ    <= busErrD;
         if (issue) begin
            weQ        <= mem_write;
            funct3Q    <= funct3;
            offQ       <= addr[1:0];
            dmemAddrQ  <= {addr[XLEN-1:2], 2'b00};
            dmemWdataQ <= storeData;
            dmemBeQ    <= beNext;
         end
         if ((stateQ == StReq) && dmem.dmem_ack && !weQ) loadDataQ <= loadExt;
      end
   end

   assign load_valid      = (stateQ == StDone) && !weQ && !killQ;
   assign load_data       = loadDataQ;
   assign access_err      = accessErrQ;
   assign bus_err         = busErrQ;
   assign dmem.dmem_req   = (stateQ == StReq);
   assign dmem.dmem_we    = weQ;
   assign dmem.dmem_addr  = dmemAddrQ;
   assign dmem.dmem_wdata = dmemWdataQ;
   assign dmem.dmem_be    = dmemBeQ;

endmodule
